// File: rtl/ctrl_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipeline
// Brief    : ID/EX, EX/MEM, MEM/WB control registers with load-use stall and
//            taken-branch flush. Optional hazard counters: CTRL_PIPE_HAZARD_CNT_EN
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipeline #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        id_ctrl,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_branch_taken,
    output logic [7:0]        ex_ctrl,
    output logic [REG_AW-1:0] ex_rd,
    output logic [3:0]        mem_ctrl,
    output logic [REG_AW-1:0] mem_rd,
    output logic [1:0]        wb_ctrl,
    output logic [REG_AW-1:0] wb_rd,
    output logic              stall,
    output logic              flush
`ifdef CTRL_PIPE_HAZARD_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
`endif
);

    localparam int c_BR_BIT = 7;
    localparam int c_MR_BIT = 2;

    logic [7:0]        r_ex_ctrl;
    logic [REG_AW-1:0] r_ex_rd;
    logic [3:0]        r_mem_ctrl;
    logic [REG_AW-1:0] r_mem_rd;
    logic [1:0]        r_wb_ctrl;
    logic [REG_AW-1:0] r_wb_rd;

    logic w_flush;
    logic w_stall;
    logic w_bubble;
    logic w_rs_match;

    // Flush has priority: a squashed ID instruction cannot have a live dependency.
    assign w_flush    = r_ex_ctrl[c_BR_BIT] & ex_branch_taken;
    assign w_rs_match = (r_ex_rd == id_rs1) | (r_ex_rd == id_rs2);
    assign w_stall    = r_ex_ctrl[c_MR_BIT] & (r_ex_rd != '0) & w_rs_match & ~w_flush;
    assign w_bubble   = w_stall | w_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_ctrl  <= '0;
            r_ex_rd    <= '0;
            r_mem_ctrl <= '0;
            r_mem_rd   <= '0;
            r_wb_ctrl  <= '0;
            r_wb_rd    <= '0;
        end else begin
            if (w_bubble) begin
                r_ex_ctrl <= '0;
                r_ex_rd   <= '0;
            end else begin
                r_ex_ctrl <= id_ctrl;
                r_ex_rd   <= id_rd;
            end
            r_mem_ctrl <= r_ex_ctrl[3:0];
            r_mem_rd   <= r_ex_rd;
            r_wb_ctrl  <= r_mem_ctrl[1:0];
            r_wb_rd    <= r_mem_rd;
        end
    end

    assign ex_ctrl  = r_ex_ctrl;
    assign ex_rd    = r_ex_rd;
    assign mem_ctrl = r_mem_ctrl;
    assign mem_rd   = r_mem_rd;
    assign wb_ctrl  = r_wb_ctrl;
    assign wb_rd    = r_wb_rd;
    assign stall    = w_stall;
    assign flush    = w_flush;

`ifdef CTRL_PIPE_HAZARD_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Both counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipeline
// Brief    : Directed plus randomized bench for ctrl_pipeline against an
//            instruction-slot reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipeline;

    localparam int REG_AW  = 5;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        id_ctrl;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              ex_branch_taken;
    logic [7:0]        ex_ctrl;
    logic [REG_AW-1:0] ex_rd;
    logic [3:0]        mem_ctrl;
    logic [REG_AW-1:0] mem_rd;
    logic [1:0]        wb_ctrl;
    logic [REG_AW-1:0] wb_rd;
    logic              stall;
    logic              flush;
`ifdef CTRL_PIPE_HAZARD_CNT_EN
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;
`endif

    always #5 clk = ~clk;

    ctrl_pipeline #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_ctrl         (id_ctrl),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .ex_branch_taken (ex_branch_taken),
        .ex_ctrl         (ex_ctrl),
        .ex_rd           (ex_rd),
        .mem_ctrl        (mem_ctrl),
        .mem_rd          (mem_rd),
        .wb_ctrl         (wb_ctrl),
        .wb_rd           (wb_rd),
        .stall           (stall),
        .flush           (flush)
`ifdef CTRL_PIPE_HAZARD_CNT_EN
        ,
        .stall_count     (stall_count),
        .flush_count     (flush_count)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the instruction occupying EX, MEM and WB, in full.
    typedef struct {
        logic [7:0]        c;
        logic [REG_AW-1:0] rd;
    } instr_t;

    instr_t slot[3];
    int     m_scnt;
    int     m_fcnt;

    function automatic logic m_flush();
        return slot[0].c[7] && ex_branch_taken;
    endfunction

    function automatic logic m_stall();
        logic dep;
        dep = (slot[0].rd == id_rs1) || (slot[0].rd == id_rs2);
        return slot[0].c[2] && (slot[0].rd != 0) && dep && !m_flush();
    endfunction

    task automatic compare_all();
        check("ex_ctrl",  32'(ex_ctrl),  32'(slot[0].c));
        check("ex_rd",    32'(ex_rd),    32'(slot[0].rd));
        check("mem_ctrl", 32'(mem_ctrl), 32'(slot[1].c[3:0]));
        check("mem_rd",   32'(mem_rd),   32'(slot[1].rd));
        check("wb_ctrl",  32'(wb_ctrl),  32'(slot[2].c[1:0]));
        check("wb_rd",    32'(wb_rd),    32'(slot[2].rd));
        check("stall",    32'(stall),    32'(m_stall()));
        check("flush",    32'(flush),    32'(m_flush()));
`ifdef CTRL_PIPE_HAZARD_CNT_EN
        check("stall_count", 32'(stall_count), 32'(m_scnt));
        check("flush_count", 32'(flush_count), 32'(m_fcnt));
`endif
    endtask

    // One clock: compare at negedge, advance model on posedge, return 1ns after it.
    task automatic cycle(input bit do_cmp = 1'b1);
        logic   s, f;
        instr_t nxt;
        @(negedge clk);
        if (do_cmp) compare_all();
        s = m_stall();
        f = m_flush();
        nxt.c  = (s || f) ? 8'h00 : id_ctrl;
        nxt.rd = (s || f) ? '0 : id_rd;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                slot[i].c  = '0;
                slot[i].rd = '0;
            end
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            slot[2] = slot[1];
            slot[1] = slot[0];
            slot[0] = nxt;
            if (s && m_scnt < CNT_MAX) m_scnt++;
            if (f && m_fcnt < CNT_MAX) m_fcnt++;
        end
        #1;
    endtask

    task automatic set_id(input logic [7:0] c, input int rs1, input int rs2, input int rd);
        id_ctrl = c;
        id_rs1  = REG_AW'(rs1);
        id_rs2  = REG_AW'(rs2);
        id_rd   = REG_AW'(rd);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ops[6];
        ops[0] = 8'h41; ops[1] = 8'h17; ops[2] = 8'hA0;
        ops[3] = 8'h18; ops[4] = 8'h13; ops[5] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            slot[i].c  = '0;
            slot[i].rd = '0;
        end
        m_scnt = 0;
        m_fcnt = 0;

        // Reset with all control bits asserted on the input
        reset = 1'b1;
        ex_branch_taken = 1'b0;
        set_id(8'hFF, 1, 2, 3);
        cycle(1'b0);
        cycle();
        cycle();
        check("rst_ex_ctrl", 32'(ex_ctrl), 32'h0);
        check("rst_wb_ctrl", 32'(wb_ctrl), 32'h0);
        reset = 1'b0;
        set_id(8'h00, 0, 0, 0);
        cycle();

        // Passthrough latency
        set_id(8'h41, 1, 2, 3);
        cycle();
        set_id(8'h00, 0, 0, 0);
        check("pass_ex_ctrl", 32'(ex_ctrl), 32'h41);
        check("pass_ex_rd",   32'(ex_rd),   32'd3);
        cycle();
        check("pass_mem_ctrl", 32'(mem_ctrl), 32'h1);
        cycle();
        check("pass_wb_ctrl", 32'(wb_ctrl), 32'h1);
        check("pass_wb_rd",   32'(wb_rd),   32'd3);
        cycle();

        // Load-use through rs1: one-cycle stall, then re-presentation
        set_id(8'h17, 0, 0, 5);
        cycle();
        set_id(8'h41, 5, 0, 6);
        #1 check("lu_stall", 32'(stall), 32'h1);
        cycle();
        check("lu_bubble", 32'(ex_ctrl), 32'h0);
        check("lu_stall_once", 32'(stall), 32'h0);
        cycle();
        check("lu_add_in_ex", 32'(ex_ctrl), 32'h41);

        // Load-use through rs2
        set_id(8'h17, 0, 0, 5);
        cycle();
        set_id(8'h41, 1, 5, 6);
        #1 check("lu_rs2_stall", 32'(stall), 32'h1);
        cycle();
        cycle();

        // Load to x0 never stalls
        set_id(8'h17, 0, 0, 0);
        cycle();
        set_id(8'h41, 0, 0, 6);
        #1 check("x0_no_stall", 32'(stall), 32'h0);
        cycle();

        // Taken branch: single-cycle flush
        set_id(8'hA0, 1, 2, 0);
        cycle();
        ex_branch_taken = 1'b1;
        set_id(8'h41, 1, 2, 7);
        #1 check("br_flush", 32'(flush), 32'h1);
        cycle();
        check("br_bubble", 32'(ex_ctrl), 32'h0);
        check("br_flush_once", 32'(flush), 32'h0);
        ex_branch_taken = 1'b0;
        cycle();

        // Not-taken branch
        set_id(8'hA0, 1, 2, 0);
        cycle();
        set_id(8'h41, 1, 2, 7);
        #1 check("br_nt_flush", 32'(flush), 32'h0);
        cycle();

        // Flush beats a coincident load-use match
        set_id(8'h85, 0, 0, 5);
        cycle();
        ex_branch_taken = 1'b1;
        set_id(8'h41, 5, 5, 6);
        #1 check("prio_stall", 32'(stall), 32'h0);
        check("prio_flush", 32'(flush), 32'h1);
        cycle();
        ex_branch_taken = 1'b0;

`ifdef CTRL_PIPE_HAZARD_CNT_EN
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_id(8'h17, 0, 0, 5);
            cycle();
            set_id(8'h41, 5, 0, 6);
            cycle();
            check("sat_stall_count", 32'(stall_count), (i < 3) ? 32'(i + 1) : 32'd3);
        end
`endif

        // Randomized traffic with a narrow register range to provoke hazards
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(3) == 0)
                set_id(8'($urandom), $urandom_range(3), $urandom_range(3), $urandom_range(3));
            else
                set_id(ops[$urandom_range(5)], $urandom_range(3), $urandom_range(3),
                       $urandom_range(3));
            ex_branch_taken = 1'($urandom);
            reset = ($urandom_range(49) == 0);
            cycle();
        end
        reset = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
- Receiving end of the main decoder's control bundle.
- Registers the decoded control bits through the ID/EX, EX/MEM and MEM/WB boundaries.
- Inserts bubbles for load-use hazards and taken branches.
- Drives the stall and flush strobes to the PC and IF/ID registers.
- Every downstream stage (ALU control, data memory, writeback mux, register file) reads its control bits only from this block.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 32, width of hazard counters (used only with the optional feature).

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  synchronous, active-high
- id_ctrl  in  8  decoded control for the instruction in ID: [0]RegWrite [1]MemtoReg [2]MemRead [3]MemWrite [4]ALUSrc [6:5]ALUOp [7]Branch
- id_rs1  in  REG_AW  rs1 field of the ID instruction
- id_rs2  in  REG_AW  rs2 field of the ID instruction
- id_rd  in  REG_AW  rd field of the ID instruction
- ex_branch_taken  in  1  branch comparison result from EX, meaningful only when ex_ctrl[7]=1
- ex_ctrl  out  8  ID/EX control register, same bit map as id_ctrl
- ex_rd  out  REG_AW  ID/EX destination register
- mem_ctrl  out  4  EX/MEM control: [0]RegWrite [1]MemtoReg [2]MemRead [3]MemWrite
- mem_rd  out  REG_AW  EX/MEM destination register
- wb_ctrl  out  2  MEM/WB control: [0]RegWrite [1]MemtoReg
- wb_rd  out  REG_AW  MEM/WB destination register
- stall  out  1  hold PC and IF/ID this cycle
- flush  out  1  squash IF/ID this cycle

Behaviour:
- Reset: all pipeline registers (ex_ctrl, ex_rd, mem_ctrl, mem_rd, wb_ctrl, wb_rd) cleared to 0 on the first rising edge with reset=1. Reset mid-operation discards all in-flight control; stall=flush=0 the cycle after.
- flush (combinational) = ex_ctrl[7] & ex_branch_taken.
- stall (combinational) = ex_ctrl[2] & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2) & ~flush.
  - rs2 is compared for every opcode. Spurious stalls on I-type and load instructions are accepted.
- ID/EX update each edge:
  - if stall or flush: ex_ctrl <= 0, ex_rd <= 0 (bubble);
  - else: ex_ctrl <= id_ctrl, ex_rd <= id_rd.
- EX/MEM update: mem_ctrl <= ex_ctrl[3:0], mem_rd <= ex_rd, unconditionally. The stalling load or the taken branch itself always advances.
- MEM/WB update: wb_ctrl <= mem_ctrl[1:0], wb_rd <= mem_rd, unconditionally.
- Latency: id_ctrl appears on ex_ctrl 1 cycle later, mem_ctrl 2 cycles later, wb_ctrl 3 cycles later.
- Stall duration: a load-use stall lasts exactly 1 cycle, because the bubble clears ex_ctrl[2] on the next edge.
- Flush duration: a flush lasts exactly 1 cycle, because the bubble clears ex_ctrl[7].
- Simultaneous stall condition and flush: flush wins and stall is 0. The ID instruction is squashed, so its dependency is irrelevant.
- rd = x0 never causes a stall.
- An instruction bubbled by stall re-presents on id_ctrl the next cycle; the block holds no copy of it.

Optional Feature:
- Macro: CTRL_PIPE_HAZARD_CNT_EN.
- When defined, adds outputs stall_count (CNT_W) and flush_count (CNT_W):
  - both reset to 0;
  - each increments by 1 on every clock edge where its strobe is 1;
  - each saturates at all-ones and does not wrap.
- When not defined, neither port nor counter logic exists; the rest of the behaviour is identical.

Test Plan:
- Reset: drive id_ctrl=8'hFF with reset=1 for 2 cycles -> ex_ctrl, mem_ctrl, wb_ctrl all 0; stall=0, flush=0.
- Passthrough: add with id_ctrl=8'h41, rd=3 -> ex_ctrl=8'h41, ex_rd=3 at +1; mem_ctrl=4'h1 at +2; wb_ctrl=2'b01, wb_rd=3 at +3.
- Load-use: lw x5 (id_ctrl=8'h17) followed by add using rs1=5 -> stall=1 for exactly one cycle, ex_ctrl=0 the next cycle, then the add enters EX after re-presentation; a dependency through rs2=5 also stalls.
- x0 load: lw with rd=0 followed by a consumer with rs1=0 -> stall stays 0.
- Branch flush: beq (id_ctrl=8'hA0) in EX with ex_branch_taken=1 -> flush=1 for one cycle, next ex_ctrl=0; with ex_branch_taken=0 -> no flush.
- Priority and counters (with CTRL_PIPE_HAZARD_CNT_EN, CNT_W=2): force flush and a load-use match in the same cycle -> stall=0, flush=1. Then four stalls -> stall_count sequence 1,2,3,3 (saturates).
